// File: rtl/fc_pkg.sv
// fc_pkg: shared widths, FSM states and output saturation for the FC/conv datapath
package fc_pkg;
    localparam int DATA_W = 16;
    localparam int FRAC_W = 10;
    localparam int ACC_W  = 24;
    typedef enum logic [2:0] {FETCH, LOAD, RUN, BIAS, OUT} fc_state_e;
    // Returns {clipped, value}; the input is any signed sum sign-extended to 64 bits
    function automatic logic [DATA_W:0] sat_to_data(input logic signed [63:0] v);
        logic signed [63:0] hi, lo;
        hi = (64'sd1 <<< (DATA_W - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (DATA_W - 1));
        return v > hi ? {1'b1, hi[DATA_W-1:0]} : v < lo ? {1'b1, lo[DATA_W-1:0]} : {1'b0, v[DATA_W-1:0]};
    endfunction
endpackage

// File: rtl/fc_mac_sequencer_if.sv
// fc_mac_sequencer_if: operand stream, multiplier link and result stream of one FC neuron
interface fc_mac_sequencer_if #(parameter int DATA_W = fc_pkg::DATA_W);
    logic              op_valid, op_ready, op_last;
    logic [DATA_W-1:0] op_x, op_w, bias;
    logic [DATA_W-1:0] mul_m, mul_r, mul_result;
    logic              mul_reset, mul_enable, mul_finish;
    logic              out_valid, out_ready, out_ovf;
    logic [DATA_W-1:0] out_data;
    modport master (
        output op_valid, op_x, op_w, op_last, bias, mul_finish, mul_result, out_ready,
        input  op_ready, mul_m, mul_r, mul_reset, mul_enable, out_valid, out_data, out_ovf
    );
    modport slave (
        input  op_valid, op_x, op_w, op_last, bias, mul_finish, mul_result, out_ready,
        output op_ready, mul_m, mul_r, mul_reset, mul_enable, out_valid, out_data, out_ovf
    );
endinterface

// File: rtl/fc_bias_relu_sat.sv
// fc_bias_relu_sat: adds bias to an accumulated sum, applies optional ReLU, saturates to DATA_W
module fc_bias_relu_sat #(
    parameter int DATA_W  = fc_pkg::DATA_W,
    parameter int ACC_W   = fc_pkg::ACC_W,
    parameter bit RELU_EN = 1'b1
) (
    input  logic signed [ACC_W-1:0]  acc,
    input  logic signed [DATA_W-1:0] bias,
    output logic        [DATA_W-1:0] data,
    output logic                     ovf
);
    import fc_pkg::*;
    logic signed [ACC_W:0] sum, act;
    always_comb begin
        sum = {acc[ACC_W-1], acc} + {{(ACC_W + 1 - DATA_W){bias[DATA_W-1]}}, bias};
        act = (RELU_EN && sum < 0) ? '0 : sum;
        {ovf, data} = sat_to_data(64'(act));
    end
endmodule

// File: rtl/fc_mac_sequencer.sv
// fc_mac_sequencer: runs one FC neuron's dot product through an external Booth multiplier,
// then adds bias, applies ReLU and saturates the result for the layer writer.
module fc_mac_sequencer #(
    parameter int DATA_W  = fc_pkg::DATA_W,
    parameter int FRAC_W  = fc_pkg::FRAC_W,
    parameter int ACC_W   = fc_pkg::ACC_W,
    parameter bit RELU_EN = 1'b1
) (
    input logic clk,
    input logic reset,
    fc_mac_sequencer_if.slave bus
);
    import fc_pkg::*;
    // Products arrive already scaled by the multiplier; ACC_W needs 8 guard bits for 256 terms
    if (FRAC_W >= DATA_W || ACC_W < DATA_W + 8) begin : g_bad_params
        $error("fc_mac_sequencer: unsupported FRAC_W/ACC_W");
    end
    fc_state_e               state;
    logic signed [ACC_W-1:0] acc;
    logic [DATA_W-1:0]       bias_q, sat_data;
    logic                    last_q, first, sat_ovf, op_fire;
    assign op_fire = bus.op_valid && bus.op_ready;
    fc_bias_relu_sat #(.DATA_W(DATA_W), .ACC_W(ACC_W), .RELU_EN(RELU_EN)) u_bias_relu_sat (
        .acc(acc), .bias(bias_q), .data(sat_data), .ovf(sat_ovf)
    );
    always_ff @(posedge clk) begin
        if (!reset) begin
            state           <= FETCH;
            acc             <= '0;
            bias_q          <= '0;
            last_q          <= 1'b0;
            first           <= 1'b1;
            bus.op_ready    <= 1'b0;
            bus.mul_m       <= '0;
            bus.mul_r       <= '0;
            bus.mul_reset   <= 1'b1;
            bus.mul_enable  <= 1'b0;
            bus.out_valid   <= 1'b0;
            bus.out_data    <= '0;
            bus.out_ovf     <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    bus.op_ready <= !op_fire;
                    if (op_fire) begin
                        bus.mul_m <= bus.op_x;
                        bus.mul_r <= bus.op_w;
                        last_q    <= bus.op_last;
                        first     <= bus.op_last;
                        if (first) bias_q <= bus.bias;
                        state     <= LOAD;
                    end
                end
                LOAD: begin
                    bus.mul_reset  <= 1'b0;
                    bus.mul_enable <= 1'b1;
                    state          <= RUN;
                end
                RUN: if (bus.mul_finish) begin
                    acc            <= acc + {{(ACC_W - DATA_W){bus.mul_result[DATA_W-1]}}, bus.mul_result};
                    bus.mul_reset  <= 1'b1;
                    bus.mul_enable <= 1'b0;
                    bus.op_ready   <= !last_q;
                    state          <= last_q ? BIAS : FETCH;
                end
                BIAS: begin
                    bus.out_data  <= sat_data;
                    bus.out_ovf   <= sat_ovf;
                    bus.out_valid <= 1'b1;
                    acc           <= '0;
                    state         <= OUT;
                end
                OUT: if (bus.out_ready) begin
                    bus.out_valid <= 1'b0;
                    bus.op_ready  <= 1'b1;
                    state         <= FETCH;
                end
                default: state <= FETCH;
            endcase
        end
    end
endmodule
